fetch_unit: RTL

Parametrised instruction-fetch sequencer for the multicycle datapath. It owns the program counter and issues one memory request per instruction. It holds each fetched word in an internal instruction register until the decode stage accepts it. On each accepted instruction it selects the next PC (sequential, branch, jump or jump-register), and it counts retired fetches.

---
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer for the multicycle datapath.
// Owns the PC, issues one memory request per instruction, holds the fetched
// word until decode accepts it, then selects the next PC and counts retires.
//
// state   | meaning
// S_FETCH | request outstanding at PC, waiting for mem_ack (wait timer running)
// S_HOLD  | instruction register valid, waiting for decode to accept
// S_HALT  | fault latched; only reset leaves this state
//
// Legal parameter ranges: WIDTH 32..64, RESET_PC word aligned, TIMEOUT 1..255.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      TIMEOUT  = 15,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready,
    input  logic [1:0]       pc_sel,
    input  logic             branch_taken,
    input  logic [15:0]      imm16,
    input  logic [25:0]      target26,
    input  logic [WIDTH-1:0] jr_addr,
    output logic             fault,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // The wait timer fires on the cycle it would reach TIMEOUT, so the
    // terminal compare is against TIMEOUT-1; an ack in that cycle still wins.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] p4;
    logic [WIDTH-1:0] br_off;
    logic [7:0]       wait_cnt;
    logic             jr_misaligned;
    logic             capture;
    logic             pc_load;
    logic             retire_inc;
    logic             fault_set;
    logic             cnt_inc;
    logic             cnt_clr;

    assign mem_addr      = pc;
    assign jr_misaligned = (pc_sel == 2'd3) && (jr_addr[1:0] != 2'b00);

    // Next-PC selection, relative to the address of the accepted instruction
    always_comb begin
        p4     = instr_pc + WIDTH'(4);
        br_off = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
        case (pc_sel)
            2'd1:    pc_nxt = branch_taken ? (p4 + br_off) : p4;
            2'd2:    pc_nxt = {p4[WIDTH-1:28], target26, 2'b00};
            2'd3:    pc_nxt = jr_addr;
            default: pc_nxt = p4;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs; mem_req is gated by rst_n so
    // it is low while reset holds the FSM in S_FETCH
    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        pc_load     = 1'b0;
        retire_inc  = 1'b0;
        fault_set   = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = rst_n;
                if (mem_ack) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault_set = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    retire_inc = 1'b1;
                    if (jr_misaligned) begin
                        fault_set = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        pc_load   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase
    end

    // Datapath registers: PC, instruction register, wait timer, fault, retire count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            instr        <= '0;
            instr_pc     <= '0;
            wait_cnt     <= '0;
            fault        <= 1'b0;
            retire_count <= '0;
        end else begin
            if (capture) begin
                instr    <= mem_rdata;
                instr_pc <= pc;
            end
            if (pc_load) begin
                pc <= pc_nxt;
            end
            if (cnt_clr) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (fault_set) begin
                fault <= 1'b1;
            end
            if (retire_inc) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

endmodule
